// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, prefetches ROM words into a small FIFO,
// and handles redirect, halt and end-of-program. Optional perf counters: FETCH_PERF_EN.
module fetch_seq #(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned ROM_WORDS = 82
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_ins,
    output logic [AW-1:0] out_pc,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    input  logic          halt_req,
`ifdef FETCH_PERF_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed,
    output logic [31:0]   perf_stall,
`endif
    output logic          done
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_END  = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   pc_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [31:0]     q_ins_q [QDEPTH];
    logic [AW-1:0]   q_pc_q  [QDEPTH];
    logic            done_q;

    logic            pc_in_rom;
    logic            full;
    logic            pop;
    logic            fetch;
    logic [AW-1:0]   pc_inc;
    logic            pc_inc_in_rom;
    logic            redir_in_rom;

    always_comb begin
        pc_in_rom     = pc_q < AW'(ROM_WORDS);
        pc_inc        = pc_q + AW'(1);
        pc_inc_in_rom = pc_inc < AW'(ROM_WORDS);
        redir_in_rom  = redir_pc < AW'(ROM_WORDS);
        full          = cnt_q == CW'(QDEPTH);
        pop           = out_valid && out_ready;
        // A full queue may still fetch when the head leaves this cycle.
        fetch         = (state_q == ST_RUN) && pc_in_rom && !redir_valid && !halt_req
                        && (!full || pop);
    end

    assign imem_addr = pc_in_rom ? pc_q : '0;
    assign out_valid = cnt_q != '0;
    assign out_ins   = q_ins_q[rd_ptr_q];
    assign out_pc    = q_pc_q[rd_ptr_q];
    assign done      = done_q;

    // Sequencer FSM, PC and prefetch queue; redirect overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= AW'(RESET_PC);
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_ins_q[i] <= '0;
                q_pc_q[i]  <= '0;
            end
        end else if (redir_valid) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pc_q     <= redir_pc;
            done_q   <= 1'b0;
            if (halt_req) begin
                state_q <= ST_HOLD;
            end else if (!redir_in_rom) begin
                state_q <= ST_END;
            end else begin
                state_q <= ST_RUN;
            end
        end else begin
            if (fetch) begin
                q_ins_q[wr_ptr_q] <= imem_data;
                q_pc_q[wr_ptr_q]  <= pc_q;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                pc_q              <= pc_inc;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q  <= cnt_q + CW'(fetch) - CW'(pop);
            done_q <= (state_q == ST_END) && (cnt_q == '0);
            case (state_q)
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_HOLD;
                    end else if (!pc_in_rom || (fetch && !pc_inc_in_rom)) begin
                        state_q <= ST_END;
                    end
                end
                ST_HOLD: begin
                    if (!halt_req) begin
                        state_q <= pc_in_rom ? ST_RUN : ST_END;
                    end
                end
                ST_END:  state_q <= ST_END;
                default: state_q <= ST_RUN;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (fetch) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redir_valid) begin
                perf_flushed_q <= perf_flushed_q + 32'(cnt_q);
            end
            if ((state_q == ST_RUN) && full && !pop) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
